sorted_insert_writer: RTL and testbench
=======================================

// Module: sorted_insert_writer
// PURPOSE
//  Writer side of the sorted-RAM search path: inserts byte A into a DEPTH x DATA_W RAM kept sorted ascending.
//  Walks from the top entry down, shifting every entry > A up one slot, then writes A into the gap.
//  Owns the RAM write port and a read port; the binary-search reader uses the same RAM once done is high.
// PARAMETERS
//  DEPTH   32  number of RAM entries
//  DATA_W  8   entry width
//  ADDR_W  5   address width, $clog2(DEPTH)
// PORTS
//  clk       input   1        system clock, all state on posedge
//  reset     input   1        asynchronous, active-low (0 = reset), one clock domain
//  start     input   1        level request; sampled in IDLE only
//  clear     input   1        synchronous; in IDLE empties the table (count <= 0), no RAM writes
//  A         input   DATA_W   value to insert, latched when start is accepted
//  rd_addr   output  ADDR_W   RAM read address; RAM registers it, rd_data valid next cycle
//  rd_data   input   DATA_W   RAM read data
//  wren      output  1        RAM write enable
//  wr_addr   output  ADDR_W   RAM write address
//  wr_data   output  DATA_W   RAM write data
//  busy      output  1        high from start accept until DONE entered
//  done      output  1        high in DONE; held until start drops
//  full      output  1        count == DEPTH
//  err_full  output  1        with done: insert rejected, RAM untouched
//  loc       output  ADDR_W   slot where A was written; valid while done && !err_full
//  count     output  ADDR_W+1 number of valid entries (0..DEPTH)
// BEHAVIOUR
//  Reset (reset==0, async): state IDLE; count=0; idx=0; loc=0; A_reg=0; busy=done=err_full=wren=0; full=0.
//  States: IDLE, RD, CMP, PLACE, DONE.
//  IDLE: clear has priority over start. start && full -> DONE, err_full=1.
//        start && count==0 -> PLACE, pos=0. start otherwise -> RD, idx=count-1. A_reg<=A on accept.
//  RD: rd_addr=idx -> CMP (1-cycle RAM read latency).
//  CMP: rd_data > A_reg (unsigned, strict): wren=1, wr_addr=idx+1, wr_data=rd_data;
//       idx==0 -> PLACE pos=0, else idx<=idx-1 -> RD.
//       rd_data <= A_reg -> PLACE pos=idx+1 (no write). Duplicates land above existing equals (stable).
//  PLACE: wren=1, wr_addr=pos, wr_data=A_reg; loc<=pos; count<=count+1 -> DONE.
//  DONE: done=1; start==0 -> IDLE (clears err_full). start held -> stay, no re-insert.
//  wren only in CMP (shift) and PLACE; at most one write per cycle; never writes addr >= DEPTH.
//  Latency: accept->DONE = 2*k+2 cycles for k>0 entries examined (k = shifts + 1 if stop compare);
//   empty table 2 cycles; full reject 1 cycle. Worst case (A below all 31 entries) 64 cycles.
//  rd_addr holds idx in all states (don't-care outside RD); wr_addr/wr_data = 0 when wren=0.
//  reset mid-insert: async abort to reset state; RAM contents undefined, count=0 so table logically empty.
//  start/clear outside IDLE/DONE ignored; A changes after accept ignored.
// STRUCTURE
//  Package sorted_ram_pkg: DEPTH/DATA_W/ADDR_W constants, state enum ins_state_t, addr_t/data_t typedefs
//   (shared with the binary-search reader).
//  One sub-module natural: sorted_insert_ctrl (FSM); top holds idx/pos/count/A_reg datapath and
//   instantiates it, matching the datapath/control split used elsewhere.
// TESTING (bench pairs the DUT with a 32x8 sync-read RAM model; checks sortedness after each insert)
//  Insert into empty: A=8'd40 -> wren at addr 0 data 40, done after 2 cycles, loc=0, count=1.
//  Sequence 10,30,20: after 20, RAM[0..2]=10,20,30; shift write addr2=30; loc=1; count=3.
//  Below all: table 1..31 (31 entries), A=0 -> 31 shifts, loc=0, count=32, full=1, done after 64 cycles.
//  Duplicate: table 5,7,9, A=7 -> loc=2, RAM=5,7,7,9; only 9 shifted.
//  Full reject: count=32, start A=8'd99 -> done=1, err_full=1 next cycle, wren never high, count=32.
//  Abort/clear: reset low during CMP -> all outputs zero immediately; later clear in IDLE -> count=0;
//   start held in DONE -> single insert only.

Source files
------------

// File: rtl/sorted_insert_writer_pkg.sv
// Shared types for the sorted-RAM insert writer and binary-search reader.
// Table geometry, address/data types and insert FSM states.
package sorted_ram_pkg;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W:0]   cnt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CMP,
    S_PLACE,
    S_DONE
  } ins_state_t;

endpackage

// File: rtl/sorted_insert_writer_if.sv
// RAM port bundle: registered-read port plus single write port.
// The writer is master; the RAM (or its model) is slave.
interface sorted_insert_writer_if;
  import sorted_ram_pkg::*;

  addr_t rd_addr;
  data_t rd_data;
  logic  wren;
  addr_t wr_addr;
  data_t wr_data;

  modport master (
    output rd_addr, wren, wr_addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  rd_addr, wren, wr_addr, wr_data,
    output rd_data
  );

endinterface

// File: rtl/sorted_insert_writer_ctrl.sv
// Insert sequencing FSM: accept, read/compare walk from the top, place.
// The datapath in the top decodes the state to drive registers and RAM.
module sorted_insert_ctrl
  import sorted_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clear,
  input  logic       full,
  input  logic       empty,
  input  logic       gt,
  input  logic       idx_zero,
  output ins_state_t state
);

  ins_state_t state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (!clear && start) begin
          if (full)       state_d = S_DONE;
          else if (empty) state_d = S_PLACE;
          else            state_d = S_RD;
        end
      end
      S_RD:    state_d = S_CMP;
      S_CMP: begin
        if (gt && !idx_zero) state_d = S_RD;
        else                 state_d = S_PLACE;
      end
      S_PLACE: state_d = S_DONE;
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/sorted_insert_writer.sv
// Sorted-table insert writer: shifts larger entries up one slot, then
// writes A into the gap. Holds the idx/pos/count/A datapath.
module sorted_insert_writer
  import sorted_ram_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   start,
  input  logic   clear,
  input  data_t  A,
  sorted_insert_writer_if.master ram,
  output logic   busy,
  output logic   done,
  output logic   full,
  output logic   err_full,
  output addr_t  loc,
  output cnt_t   count
);

  ins_state_t state;

  addr_t idx_q, idx_d;
  addr_t pos_q, pos_d;
  addr_t loc_q, loc_d;
  cnt_t  count_q, count_d;
  data_t a_q, a_d;
  logic  err_q, err_d;

  logic  gt, shift, place;
  cnt_t  cnt_m1;

  assign gt     = ram.rd_data > a_q;
  assign cnt_m1 = count_q - cnt_t'(1);
  assign full   = count_q == cnt_t'(DEPTH);

  sorted_insert_ctrl u_ctrl (
    .clk      (clk),
    .rst_n    (reset),
    .start    (start),
    .clear    (clear),
    .full     (full),
    .empty    (count_q == '0),
    .gt       (gt),
    .idx_zero (idx_q == '0),
    .state    (state)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      pos_q   <= '0;
      loc_q   <= '0;
      count_q <= '0;
      a_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      loc_q   <= loc_d;
      count_q <= count_d;
      a_q     <= a_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    idx_d   = idx_q;
    pos_d   = pos_q;
    loc_d   = loc_q;
    count_d = count_q;
    a_d     = a_q;
    err_d   = err_q;
    unique case (state)
      S_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (start) begin
          a_d = A;
          if (full)                err_d = 1'b1;
          else if (count_q == '0)  pos_d = '0;
          else                     idx_d = cnt_m1[ADDR_W-1:0];
        end
      end
      S_CMP: begin
        // Stop on first entry <= A so equal values stay below the new one
        if (gt) begin
          if (idx_q == '0) pos_d = '0;
          else             idx_d = idx_q - addr_t'(1);
        end else begin
          pos_d = idx_q + addr_t'(1);
        end
      end
      S_PLACE: begin
        loc_d   = pos_q;
        count_d = count_q + cnt_t'(1);
      end
      S_DONE: begin
        if (!start) err_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign shift = (state == S_CMP) && gt;
  assign place = (state == S_PLACE);

  always_comb begin
    ram.rd_addr = idx_q;
    ram.wren    = 1'b0;
    ram.wr_addr = '0;
    ram.wr_data = '0;
    unique case (1'b1)
      shift: begin
        ram.wren    = 1'b1;
        ram.wr_addr = idx_q + addr_t'(1);
        ram.wr_data = ram.rd_data;
      end
      place: begin
        ram.wren    = 1'b1;
        ram.wr_addr = pos_q;
        ram.wr_data = a_q;
      end
      default: ;
    endcase
  end

  assign busy     = (state == S_RD) || (state == S_CMP) || (state == S_PLACE);
  assign done     = (state == S_DONE);
  assign err_full = err_q;
  assign loc      = loc_q;
  assign count    = count_q;

endmodule

// File: tb/tb_sorted_insert_writer.sv
// Bench for sorted_insert_writer: 32x8 sync-read RAM model, directed
// table, corner sequences and random inserts against a sorted-queue model.
module tb_sorted_insert_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic [7:0] a_in;
  logic       busy, done, full, err_full;
  logic [4:0] loc;
  logic [5:0] count;

  sorted_insert_writer_if ram_if ();

  sorted_insert_writer dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .clear    (clear),
    .A        (a_in),
    .ram      (ram_if.master),
    .busy     (busy),
    .done     (done),
    .full     (full),
    .err_full (err_full),
    .loc      (loc),
    .count    (count)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [32];

  always @(posedge clk) begin
    if (ram_if.wren) mem[ram_if.wr_addr] <= ram_if.wr_data;
    ram_if.rd_data <= mem[ram_if.rd_addr];
  end

  int checks   = 0;
  int failures = 0;
  int mdl[$];

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic predict(input int a, output int e_loc, output int e_cnt,
                         output int e_lat, output int e_sh, output int e_err);
    int n;
    n = mdl.size();
    e_loc = 0;
    if (n == 32) begin
      e_err = 1; e_cnt = 32; e_lat = 1; e_sh = 0;
    end else begin
      foreach (mdl[i]) if (mdl[i] <= a) e_loc++;
      e_sh  = n - e_loc;
      e_err = 0;
      e_cnt = n + 1;
      e_lat = (n == 0) ? 2 : 2 * (e_sh + ((e_loc > 0) ? 1 : 0)) + 2;
    end
  endtask

  task automatic do_clear();
    int nwr;
    clear = 1'b1;
    nwr = 0;
    @(posedge clk);
    @(negedge clk);
    if (ram_if.wren) nwr++;
    clear = 1'b0;
    mdl.delete();
    chk("clear_cnt", int'(count), 0);
    chk("clear_wr", nwr, 0);
  endtask

  task automatic do_insert(input int a, input int hold,
                           input int e_loc, input int e_cnt, input int e_lat,
                           input int e_sh, input int e_err,
                           input int e_wa, input int e_wd);
    int lat, nwr, wa, wd, bad, drop;
    lat = 0; nwr = 0; wa = -1; wd = -1; bad = 0; drop = 0;
    start = 1'b1;
    a_in  = 8'(a);
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (lat == 1) a_in = ~8'(a);
      if (ram_if.wren) begin
        if (nwr == 0) begin
          wa = int'(ram_if.wr_addr);
          wd = int'(ram_if.wr_data);
        end
        nwr++;
      end
    end while (!done && lat < 100);
    chk("latency", lat, e_lat);
    chk("busy_done", int'(busy), 0);
    chk("err_full", int'(err_full), e_err);
    if (e_err == 0) chk("loc", int'(loc), e_loc);
    chk("count", int'(count), e_cnt);
    chk("full", int'(full), (e_cnt == 32) ? 1 : 0);
    if (e_wa >= 0) begin
      chk("first_wa", wa, e_wa);
      chk("first_wd", wd, e_wd);
    end
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_if.wren) nwr++;
      if (!done) drop++;
    end
    if (hold > 0) begin
      chk("hold_done", drop, 0);
      chk("hold_cnt", int'(count), e_cnt);
    end
    chk("writes", nwr, (e_err != 0) ? 0 : e_sh + 1);
    if (e_err == 0) mdl.insert(e_loc, a);
    foreach (mdl[i]) if (int'(mem[i]) !== mdl[i]) bad++;
    chk("ram", bad, 0);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("done_drop", int'(done), 0);
    chk("err_drop", int'(err_full), 0);
  endtask

  task automatic model_insert(input int a, input int hold);
    int l, c, t, s, e;
    predict(a, l, c, t, s, e);
    do_insert(a, hold, l, c, t, s, e, -1, -1);
  endtask

  typedef struct {
    bit clr;
    int a;
    int loc;
    int cnt;
    int lat;
    int sh;
    int wa;
    int wd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{1'b1, 40, 0, 1, 2, 0, 0, 40};
    tbl[1] = '{1'b1, 10, 0, 1, 2, 0, 0, 10};
    tbl[2] = '{1'b0, 30, 1, 2, 4, 0, 1, 30};
    tbl[3] = '{1'b0, 20, 1, 3, 6, 1, 2, 30};
    tbl[4] = '{1'b1,  5, 0, 1, 2, 0, 0,  5};
    tbl[5] = '{1'b0,  7, 1, 2, 4, 0, 1,  7};
    tbl[6] = '{1'b0,  9, 2, 3, 4, 0, 2,  9};
    tbl[7] = '{1'b0,  7, 2, 4, 6, 1, 3,  9};

    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    a_in  = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(count), 0);
    chk("rst_wren", int'(ram_if.wren), 0);
    chk("rst_loc", int'(loc), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      if (tbl[i].clr) do_clear();
      do_insert(tbl[i].a, 0, tbl[i].loc, tbl[i].cnt, tbl[i].lat,
                tbl[i].sh, 0, tbl[i].wa, tbl[i].wd);
    end
    chk("dup_ram2", int'(mem[2]), 7);
    chk("dup_ram3", int'(mem[3]), 9);

    // Below-all: fill 1..31 then insert 0
    do_clear();
    for (int v = 1; v <= 31; v++) model_insert(v, 0);
    do_insert(0, 0, 0, 32, 64, 31, 0, 31, 31);
    do_insert(99, 3, 0, 32, 1, 0, 1, -1, -1);

    // Start held in DONE: single insert only
    do_clear();
    model_insert(50, 4);
    model_insert(60, 2);

    // Reset during CMP
    start = 1'b1;
    a_in  = 8'd55;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_abort_wren", int'(ram_if.wren), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_wren", int'(ram_if.wren), 0);
    chk("abort_cnt", int'(count), 0);
    chk("abort_wa", int'(ram_if.wr_addr), 0);
    chk("abort_wd", int'(ram_if.wr_data), 0);
    chk("abort_rda", int'(ram_if.rd_addr), 0);
    start = 1'b0;
    mdl.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_insert(77, 0);

    // Clear wins over start in IDLE
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("clr_pri_busy", int'(busy), 0);
    chk("clr_pri_cnt", int'(count), 0);
    clear = 1'b0;
    start = 1'b0;
    mdl.delete();
    @(negedge clk);
    model_insert(3, 0);

    // Random inserts, skewed toward duplicates, through to full rejects
    do_clear();
    for (int i = 0; i < 60; i++) begin
      int v;
      if (i == 10) do_clear();
      v = ($urandom_range(0, 1) == 0) ? 16 * $urandom_range(0, 15)
                                      : $urandom_range(0, 255);
      model_insert(v, $urandom_range(0, 2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
